// File: rtl/multimode_ff_register.sv
// multimode_ff_register: WIDTH-bit register of JK-style cells with eight
// update modes (D, T, JK, SR, shift left/right, count up, hold), a sticky
// SR-illegal error flag, a count-wrap pulse and complementary outputs.
module multimode_ff_register #(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sin,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sout,
  output logic             wrap,
  output logic             err
);

  typedef enum logic [2:0] {
    MODE_D     = 3'b000,
    MODE_T     = 3'b001,
    MODE_JK    = 3'b010,
    MODE_SR    = 3'b011,
    MODE_SHL   = 3'b100,
    MODE_SHR   = 3'b101,
    MODE_COUNT = 3'b110,
    MODE_HOLD  = 3'b111
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_next;
  logic             sout_next;
  logic             wrap_next;
  logic             sr_illegal;

  assign mode_sel   = mode_e'(mode);
  assign sr_illegal = en && (mode_sel == MODE_SR) && (|(a & b));

  // Next-state selection for q and the registered side outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a variable unassigned (no latch).
    q_next    = q;
    sout_next = 1'b0;
    wrap_next = 1'b0;
    if (en) begin
      unique case (mode_sel)
        MODE_D:     q_next = a;
        MODE_T:     q_next = q ^ a;
        MODE_JK:    q_next = (a & ~q) | (~b & q);
        // S=R=1 falls into the hold term: a^b is 0 for that bit.
        MODE_SR:    q_next = (a & ~b) | (q & ~(a ^ b));
        MODE_SHL: begin
          q_next    = {q[WIDTH-2:0], sin};
          sout_next = q[WIDTH-1];
        end
        MODE_SHR: begin
          q_next    = {sin, q[WIDTH-1:1]};
          sout_next = q[0];
        end
        MODE_COUNT: begin
          q_next    = q + 1'b1;
          wrap_next = &q;
        end
        MODE_HOLD:  q_next = q;
        default:    q_next = q;
      endcase
    end
  end

  // State register: synchronous reset, then update; err is sticky with
  // set taking priority over clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values regardless of statement order.
    if (rst) begin
      q    <= RST_VAL;
      sout <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      q    <= q_next;
      sout <= sout_next;
      wrap <= wrap_next;
      if (sr_illegal)   err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  assign q_bar = ~q;

endmodule

// File: doc/multimode_ff_register.md
Name: multimode_ff_register

Overview:
- Parametrised WIDTH-bit register; every bit is a JK-style storage cell.
- A 3-bit mode input selects how the register updates each cycle: D-load, T-toggle, JK, SR, shift left, shift right, count up, or hold.
- Provides a sticky SR-illegal error flag, a count-wrap pulse, and complementary outputs.
- Serves as the general-purpose storage and counting primitive that supersedes the single-bit D/T/JK flip-flop cells in sequential designs.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  update enable; 0 = hold regardless of mode.
- mode  input  3  operation select (see Behaviour).
- a  input  WIDTH  operand A; meaning is D, T, J, or S depending on mode.
- b  input  WIDTH  operand B; meaning is K or R depending on mode (ignored otherwise).
- sin  input  1  serial input for the shift modes.
- err_clr  input  1  clears the sticky err flag.
- q  output  WIDTH  register state.
- q_bar  output  WIDTH  always ~q.
- sout  output  1  bit shifted out during the last shift cycle; otherwise 0.
- wrap  output  1  one-cycle pulse when count-up wraps from all-ones to 0.
- err  output  1  sticky flag: an illegal SR condition (S=R=1) has occurred.

Behaviour:
- All state updates on the rising edge of clk.
- Reset (synchronous, highest priority): q=RST_VAL, sout=0, wrap=0, err=0. Reset overrides en, mode, and err_clr in the same cycle.
- When en=0: q holds; sout=0 and wrap=0 next cycle; err holds (err_clr is still honoured).
- Mode encoding (applies when en=1):
  - 000 D: q <= a.
  - 001 T: q <= q ^ a.
  - 010 JK, per bit: J=a[i], K=b[i]; 00 hold, 10 set, 01 clear, 11 toggle. Equivalent to q <= (a & ~q) | (~b & q).
  - 011 SR, per bit: S=a[i], R=b[i]; 10 set, 01 clear, 00 hold. 11 is illegal: that bit holds and err sets.
  - 100 shift left: q <= {q[WIDTH-2:0], sin}; sout <= q[WIDTH-1].
  - 101 shift right: q <= {sin, q[WIDTH-1:1]}; sout <= q[0].
  - 110 count up: q <= q+1, modulo 2^WIDTH; wrap <= (q == all ones).
  - 111 hold: q unchanged.
- sout and wrap are registered. Each is 1 only in the cycle after a qualifying operation and 0 otherwise.
- err priority: rst > set-condition > err_clr. A simultaneous illegal-SR event and err_clr leaves err=1.
- Latency: q reflects the operands one cycle after the capturing edge. There is no combinational path from inputs to outputs.
- q_bar is combinational from q, so q_bar==~q holds in every cycle, including during reset.
- A mode change takes effect on the same edge. No internal state other than q, sout, wrap, and err.
- Reset asserted mid-sequence (for example mid-count) discards the operation in that cycle.

Test Plan:
- Reset and D mode (WIDTH=8): rst=1 for one edge -> q=00, q_bar=FF, err=0. Then mode=000, a=A5, en=1 -> q=A5 after one edge. Then en=0, a=3C -> q stays A5.
- T and JK modes: q=A5; mode=001, a=0F -> q=AA. Then mode=010, a=F0, b=0F -> q=F0. Then a=FF, b=FF -> q=0F. Then a=00, b=00 -> q=0F.
- SR illegal: q=00; mode=011, a=81, b=01 -> q=80, err=1. Next cycle: err_clr=1 with a=b=00 -> err=0, q=80. Repeat an S=R=1 event together with err_clr=1 -> err stays 1.
- Shifts: q=81, sin=0, mode=100 -> q=02, sout=1. Then mode=101, sin=1 -> q=81, sout=0. Eight shift-left cycles with sin=1 from q=00 -> q=FF.
- Count wrap: q=FE, mode=110 -> q=FF, wrap=0. Next edge -> q=00, wrap=1. Next edge -> q=01, wrap=0.
- Reset mid-operation: counting at q=7F, assert rst with mode=110 and err=1 -> q=RST_VAL, wrap=0, err=0. Re-run with RST_VAL=8'h55 -> q=55.
